// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div : sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        request pulse, only looked at while idle
//   a, b         dividend / divisor (unsigned), latched when start is accepted
//   quo, rem     registered quotient / remainder, held until the next completion
//   finish       one-cycle completion strobe
//   busy         high from acceptance until the return to idle
//   div_by_zero  raised with finish when b was 0, cleared by the next accepted start
//
// Timing: accepted at edge E, results and finish appear at edge E+WIDTH
// (E+1 for a zero divisor), and the block is idle again one edge later.
// -----------------------------------------------------------------------------
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             finish,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend, quotient bits shift in at the LSB
    logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor
    logic [WIDTH-1:0]   r_q, r_d;          // partial remainder, always < divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // iterations left
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               fin_q, fin_d;
    logic               busy_q, busy_d;
    logic               dz_q, dz_d;

    // One restoring step. The shifted remainder needs WIDTH+1 bits; when it is
    // >= divisor the difference is below the divisor, so WIDTH bits hold it.
    logic [WIDTH:0]     r_sh;
    logic               q_bit;
    logic [WIDTH-1:0]   r_nxt;

    always_comb begin
        r_sh  = {r_q, dvd_q[WIDTH-1]};
        q_bit = (r_sh >= {1'b0, dvs_q});
        r_nxt = q_bit ? (r_sh[WIDTH-1:0] - dvs_q) : r_sh[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        fin_d   = 1'b0;
        busy_d  = busy_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = a;
                    dvs_d   = b;
                    r_d     = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (dvs_q == '0) begin
                    // Zero divisor resolves on the first cycle after acceptance
                    // without iterating: saturated quotient, dividend as remainder.
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dz_d    = 1'b1;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d   = r_nxt;
                    dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quo_d   = {dvd_q[WIDTH-2:0], q_bit};
                        rem_d   = r_nxt;
                        fin_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
        end
    end

    assign quo         = quo_q;
    assign rem         = rem_q;
    assign finish      = fin_q;
    assign busy        = busy_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div : directed bench for seq_div (WIDTH=8) with a transaction-level
// reference model compared against the DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] quo, rem;
    logic         finish, busy, div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .quo         (quo),
        .rem         (rem),
        .finish      (finish),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Results come from plain / and %; timing from the handshake rules:
    // finish WIDTH edges after acceptance (1 for b==0), idle one edge later.
    logic [W-1:0] m_quo = '0, m_rem = '0, p_quo = '0, p_rem = '0;
    logic         m_fin = 1'b0, m_busy = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int           m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_quo <= '0; m_rem <= '0; m_fin <= 1'b0; m_busy <= 1'b0; m_dz <= 1'b0;
            m_left <= 0;
        end else if (m_fin) begin
            m_fin  <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_fin <= 1'b1; m_quo <= p_quo; m_rem <= p_rem; m_dz <= p_dz;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_dz   <= 1'b0;
            if (b == 0) begin
                p_quo <= '1; p_rem <= a; p_dz <= 1'b1; m_left <= 1;
            end else begin
                p_quo <= a / b; p_rem <= a % b; p_dz <= 1'b0; m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("quo", 32'(quo), 32'(m_quo));
            chk("rem", 32'(rem), 32'(m_rem));
            chk("finish", 32'(finish), 32'(m_fin));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
        end
    end

    // ---------------- one operation ----------------
    // Called at a falling edge; returns at a falling edge with the DUT idle.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int hold,
                      input bit scramble,
                      output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                      output int lat, output int bc, output int nfin);
        bit got = 1'b0;
        q = '0; r = '0; dz = 1'b0; lat = 0; bc = 0; nfin = 0;
        a = ia; b = ib; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == hold) start = 1'b0;
            if (scramble && n == 3) begin
                a = W'($urandom); b = W'($urandom);
            end
            if (busy) bc++;
            if (finish) begin
                nfin++;
                if (!got) begin
                    got = 1'b1; lat = n; q = quo; r = rem; dz = div_by_zero;
                end
            end
            if (got && !busy && !finish) break;
        end
        start = 1'b0;
        if (!got) chk("op_timeout", 0, 1);
    endtask

    logic [W-1:0] q, r;
    logic         dz;
    int           lat, bc, nfin;
    integer       seed = 32'h5eed_d1f0;

    // boundary table: a, b, quo, rem
    logic [W-1:0] bnd [4][4] = '{'{8'd255, 8'd1, 8'd255, 8'd0},
                                '{8'd5,   8'd9, 8'd0,   8'd5},
                                '{8'd0,   8'd3, 8'd0,   8'd0},
                                '{8'd255, 8'd255, 8'd1, 8'd0}};

    initial begin
        #1 rst = 1'b0;
        #20 rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_quo", 32'(quo), 0);
        chk("reset_rem", 32'(rem), 0);
        chk("reset_finish", 32'(finish), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dz", 32'(div_by_zero), 0);

        // basic divide
        op(8'd200, 8'd7, 1, 1'b0, q, r, dz, lat, bc, nfin);
        chk("basic_quo", 32'(q), 28);
        chk("basic_rem", 32'(r), 4);
        chk("basic_dz", 32'(dz), 0);
        chk("basic_latency", lat, 9);
        chk("basic_busy_cycles", bc, 9);
        chk("basic_finish_count", nfin, 1);

        // boundaries
        for (int i = 0; i < 4; i++) begin
            op(bnd[i][0], bnd[i][1], 1, 1'b0, q, r, dz, lat, bc, nfin);
            chk("bnd_quo", 32'(q), 32'(bnd[i][2]));
            chk("bnd_rem", 32'(r), 32'(bnd[i][3]));
            chk("bnd_latency", lat, 9);
        end

        // divide by zero, then held through idle, then cleared by next start
        op(8'h80, 8'd0, 1, 1'b0, q, r, dz, lat, bc, nfin);
        chk("dz_quo", 32'(q), 32'hFF);
        chk("dz_rem", 32'(r), 32'h80);
        chk("dz_flag", 32'(dz), 1);
        chk("dz_latency", lat, 2);
        chk("dz_busy_cycles", bc, 2);
        repeat (3) @(negedge clk);
        chk("dz_held", 32'(div_by_zero), 1);
        chk("dz_quo_held", 32'(quo), 32'hFF);
        op(8'd10, 8'd2, 1, 1'b0, q, r, dz, lat, bc, nfin);
        chk("dz_cleared", 32'(dz), 0);
        chk("after_dz_quo", 32'(q), 5);

        // start held 2 cycles, operands scrambled during CALC
        op(8'd77, 8'd5, 2, 1'b1, q, r, dz, lat, bc, nfin);
        chk("hold2_finish_count", nfin, 1);
        chk("hold2_quo", 32'(q), 15);
        chk("hold2_rem", 32'(r), 2);

        // start held high: back-to-back every W+2 cycles
        begin
            int t[$];
            a = 8'd50; b = 8'd6; start = 1'b1;
            for (int n = 1; n <= 35; n++) begin
                @(negedge clk);
                if (finish) begin
                    t.push_back(n);
                    chk("b2b_quo", 32'(quo), 8);
                    chk("b2b_rem", 32'(rem), 2);
                end
            end
            start = 1'b0;
            chk("b2b_count", t.size(), 3);
            if (t.size() == 3) begin
                chk("b2b_first", t[0], 9);
                chk("b2b_period1", t[1] - t[0], W + 2);
                chk("b2b_period2", t[2] - t[1], W + 2);
            end
            for (int n = 0; n < 20 && busy; n++) @(negedge clk);
            chk("b2b_idle", 32'(busy), 0);
        end

        // reset in the 4th CALC cycle
        a = 8'd200; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_quo", 32'(quo), 0);
        chk("mid_rst_rem", 32'(rem), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_finish", 32'(finish), 0);
        @(negedge clk);
        rst = 1'b1;
        nfin = 0;
        repeat (15) begin
            @(negedge clk);
            if (finish) nfin++;
        end
        chk("mid_rst_no_finish", nfin, 0);
        op(8'd100, 8'd10, 1, 1'b0, q, r, dz, lat, bc, nfin);
        chk("post_rst_quo", 32'(q), 10);
        chk("post_rst_rem", 32'(r), 0);

        // randomized sweep against the division identity
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($random(seed));
            rb = W'($random(seed));
            if (rb == 0) rb = 8'd1;
            op(ra, rb, 1, 1'b0, q, r, dz, lat, bc, nfin);
            chk("rnd_identity", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
            chk("rnd_rem_lt_b", 32'(r < rb), 1);
            chk("rnd_finish_count", nfin, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
